scan_axis_counter: RTL and testbench

Single-axis raster timing engine for the VGA display path: a free-running, enable-gated timing counter that wraps at a programmable terminal value and emits a one-clock end-of-period pulse, plus a pixel-address counter that advances only inside the programmed display window. Two instances build a full raster. The horizontal instance is enabled by the pixel-rate strobe. The vertical instance is enabled by the horizontal instance's `TRIGGER_OUT`. Sync/colour logic downstream decodes `TIME_COUNT`; the frame buffer is addressed by `PIXCOUNT`.

---
 rtl/scan_axis_counter.sv | 61 ++++++
 tb/tb_scan_axis_counter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_axis_counter.sv
// Single-axis raster timing counter with wrap pulse and
// display-window pixel address counter.
module scan_axis_counter #(
  parameter int MAX_VALUE      = 799,
  parameter int SIZE           = 10,
  parameter int ADDR_SIZE      = 10,
  parameter int BACK_PORCH_END = 143,
  parameter int DISPLAY_END    = 783
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 ENABLE,
  output logic [SIZE-1:0]      TIME_COUNT,
  output logic                 TRIGGER_OUT,
  output logic [ADDR_SIZE-1:0] PIXCOUNT
);

  localparam logic [SIZE-1:0] LP_MAX = SIZE'(MAX_VALUE);
  localparam logic [SIZE-1:0] LP_BPE = SIZE'(BACK_PORCH_END);
  localparam logic [SIZE-1:0] LP_DE  = SIZE'(DISPLAY_END);

  logic [SIZE-1:0]      r_time;
  logic                 r_trig;
  logic [ADDR_SIZE-1:0] r_pix;

  logic w_at_max;
  logic w_in_win;

  assign w_at_max = (r_time == LP_MAX);
  assign w_in_win = (r_time >= LP_BPE)
                 && (r_time < LP_DE);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_time <= '0;
    end else if (ENABLE) begin
      if (w_at_max) r_time <= '0;
      else          r_time <= r_time + 1'b1;
    end
  end

  // Reloaded every edge so the pulse self-clears even with ENABLE low
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_trig <= 1'b0;
    else         r_trig <= ENABLE && w_at_max;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_pix <= '0;
    end else if (ENABLE) begin
      if (w_in_win) r_pix <= r_pix + 1'b1;
      else          r_pix <= '0;
    end
  end

  assign TIME_COUNT  = r_time;
  assign TRIGGER_OUT = r_trig;
  assign PIXCOUNT    = r_pix;

endmodule

// File: tb/tb_scan_axis_counter.sv
// Directed bench for scan_axis_counter: small instances,
// address wrap, small cascade and default H/V cascade.
module tb_scan_axis_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic en_h = 1'b0;

  always #5 clk = ~clk;

  logic [3:0] tc, tc_w;
  logic       tr, tr_w;
  logic [2:0] px;
  logic [1:0] px_w;
  logic [1:0] v_tc;
  logic       v_tr;
  logic [1:0] v_px;
  logic [9:0] h_tc, h_px, vd_tc;
  logic       h_tr, vd_tr;
  logic [8:0] vd_px;

  scan_axis_counter #(
    .MAX_VALUE(9), .SIZE(4), .ADDR_SIZE(3),
    .BACK_PORCH_END(2), .DISPLAY_END(7)
  ) dut (
    .CLK(clk), .RESETN(rst_n), .ENABLE(en),
    .TIME_COUNT(tc), .TRIGGER_OUT(tr), .PIXCOUNT(px)
  );

  scan_axis_counter #(
    .MAX_VALUE(9), .SIZE(4), .ADDR_SIZE(2),
    .BACK_PORCH_END(2), .DISPLAY_END(7)
  ) dut_w (
    .CLK(clk), .RESETN(rst_n), .ENABLE(en),
    .TIME_COUNT(tc_w), .TRIGGER_OUT(tr_w), .PIXCOUNT(px_w)
  );

  scan_axis_counter #(
    .MAX_VALUE(3), .SIZE(2), .ADDR_SIZE(2),
    .BACK_PORCH_END(1), .DISPLAY_END(3)
  ) dut_v (
    .CLK(clk), .RESETN(rst_n), .ENABLE(tr),
    .TIME_COUNT(v_tc), .TRIGGER_OUT(v_tr), .PIXCOUNT(v_px)
  );

  scan_axis_counter h_def (
    .CLK(clk), .RESETN(rst_n), .ENABLE(en_h),
    .TIME_COUNT(h_tc), .TRIGGER_OUT(h_tr), .PIXCOUNT(h_px)
  );

  scan_axis_counter #(
    .MAX_VALUE(520), .SIZE(10), .ADDR_SIZE(9),
    .BACK_PORCH_END(34), .DISPLAY_END(510)
  ) v_def (
    .CLK(clk), .RESETN(rst_n), .ENABLE(h_tr),
    .TIME_COUNT(vd_tc), .TRIGGER_OUT(vd_tr), .PIXCOUNT(vd_px)
  );

  int pass_cnt = 0;
  int total = 0;

  // Pixel address as a function of TIME_COUNT
  int pt  [10] = '{0, 0, 0, 1, 2, 3, 4, 5, 0, 0};
  int ptw [10] = '{0, 0, 0, 1, 2, 3, 0, 1, 0, 0};

  int e_tc = 0;
  int e_tr = 0;
  int e_v  = 0;

  task automatic model_clear();
    e_tc = 0;
    e_tr = 0;
    e_v  = 0;
  endtask

  task automatic step();
    int n_tc, n_tr, n_v;
    n_tr = (en && e_tc == 9) ? 1 : 0;
    n_tc = en ? ((e_tc == 9) ? 0 : e_tc + 1) : e_tc;
    n_v  = (e_tr == 1) ? ((e_v == 3) ? 0 : e_v + 1) : e_v;
    @(posedge clk);
    #1;
    e_tc = n_tc;
    e_tr = n_tr;
    e_v  = n_v;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({tc, tr, px, h_tc, h_px} !== '0)
      $display("FAIL reset_init got tc=%0d tr=%0d px=%0d want 0",
               tc, tr, px);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b1;
    model_clear();
    step();
    total++;
    if (tc !== 4'd1)
      $display("FAIL reset_release got tc=%0d want 1", tc);
    else pass_cnt++;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if (tc !== 4'd0 || tr !== 1'b0 || px !== 3'd0)
      $display("FAIL reset_async got tc=%0d tr=%0d px=%0d want 0",
               tc, tr, px);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_continuous();
    logic prev_tr;
    prev_tr = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      total++;
      if (tc !== 4'(e_tc))
        $display("FAIL cont_tc[%0d] got %0d want %0d", i, tc, e_tc);
      else pass_cnt++;
      total++;
      if (tr !== 1'(e_tr))
        $display("FAIL cont_trig[%0d] got %0b want %0d", i, tr, e_tr);
      else pass_cnt++;
      total++;
      if (prev_tr && tr)
        $display("FAIL cont_trig_wide[%0d] got 1 twice want 0", i);
      else pass_cnt++;
      prev_tr = tr;
      total++;
      if (px !== 3'(pt[e_tc]))
        $display("FAIL cont_pix[%0d] got %0d want %0d",
                 i, px, pt[e_tc]);
      else pass_cnt++;
      total++;
      if (px_w !== 2'(ptw[e_tc]))
        $display("FAIL addr_wrap[%0d] got %0d want %0d",
                 i, px_w, ptw[e_tc]);
      else pass_cnt++;
      total++;
      if (v_tc !== 2'(e_v))
        $display("FAIL cascade_small[%0d] got %0d want %0d",
                 i, v_tc, e_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_gated();
    int prev;
    for (int i = 0; i < 12; i++) begin
      en = (i % 2 == 0);
      prev = e_tc;
      step();
      total++;
      if (tc !== 4'(e_tc))
        $display("FAIL gated_tc[%0d] got %0d want %0d (from %0d)",
                 i, tc, e_tc, prev);
      else pass_cnt++;
      total++;
      if (tr !== 1'(e_tr))
        $display("FAIL gated_trig[%0d] got %0b want %0d",
                 i, tr, e_tr);
      else pass_cnt++;
      total++;
      if (px !== 3'(pt[e_tc]))
        $display("FAIL gated_pix[%0d] got %0d want %0d",
                 i, px, pt[e_tc]);
      else pass_cnt++;
    end
    en = 1'b1;
    for (int i = 0; i < 20 && e_tc != 9; i++) step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (tc !== 4'd9 || tr !== 1'b0 || px !== 3'd0)
        $display("FAIL hold_max[%0d] got tc=%0d tr=%0b px=%0d want 9/0/0",
                 i, tc, tr, px);
      else pass_cnt++;
    end
    en = 1'b1;
    step();
    total++;
    if (tc !== 4'd0 || tr !== 1'b1)
      $display("FAIL wrap_after_hold got tc=%0d tr=%0b want 0/1",
               tc, tr);
    else pass_cnt++;
    en = 1'b0;
    step();
    total++;
    if (tc !== 4'd0 || tr !== 1'b0)
      $display("FAIL trig_clear_en0 got tc=%0d tr=%0b want 0/0",
               tc, tr);
    else pass_cnt++;
  endtask

  task automatic test_reset_pending();
    en = 1'b1;
    for (int i = 0; i < 20 && e_tc != 9; i++) step();
    rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1;
    total++;
    if (tc !== 4'd0 || tr !== 1'b0)
      $display("FAIL reset_pending got tc=%0d tr=%0b want 0/0",
               tc, tr);
    else pass_cnt++;
    rst_n = 1'b1;
    model_clear();
    step();
    total++;
    if (tc !== 4'd1 || tr !== 1'b0)
      $display("FAIL reset_pending_rel got tc=%0d tr=%0b want 1/0",
               tc, tr);
    else pass_cnt++;
  endtask

  task automatic test_cascade_default();
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    en_h = 1'b1;
    for (int k = 1; k <= 1601; k++) begin
      @(posedge clk);
      #1;
      if (k == 783) begin
        total++;
        if (h_tc !== 10'd783 || h_px !== 10'd640)
          $display("FAIL h_peak got tc=%0d px=%0d want 783/640",
                   h_tc, h_px);
        else pass_cnt++;
      end
      if (k == 784) begin
        total++;
        if (h_px !== 10'd0)
          $display("FAIL h_after_peak got px=%0d want 0", h_px);
        else pass_cnt++;
      end
      if (k == 800) begin
        total++;
        if (h_tc !== 10'd0 || h_tr !== 1'b1 || vd_tc !== 10'd0)
          $display("FAIL h_wrap got tc=%0d tr=%0b v=%0d want 0/1/0",
                   h_tc, h_tr, vd_tc);
        else pass_cnt++;
      end
      if (k == 801 || k == 1600) begin
        total++;
        if (vd_tc !== 10'd1)
          $display("FAIL v_step1 at %0d got %0d want 1", k, vd_tc);
        else pass_cnt++;
      end
      if (k == 1601) begin
        total++;
        if (vd_tc !== 10'd2 || vd_tr !== 1'b0)
          $display("FAIL v_step2 got %0d tr=%0b want 2/0",
                   vd_tc, vd_tr);
        else pass_cnt++;
      end
    end
    en_h = 1'b0;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gated();
    test_reset_pending();
    test_cascade_default();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
